if_prefetch_stage: RTL

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue and a pipelined request/response instruction-memory port. It is the successor of the single-register fetch stage: it sits between instruction memory and the IF/ID pipeline register. It keeps up to DEPTH fetches in flight or buffered, honours `freeze` from hazard detection, and on `branchTaken` redirects, discards every stale fetch, and pulses `flush` to the IF/ID register.

---
 rtl/if_prefetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
// Instruction-fetch stage with a DEPTH-entry prefetch queue in front of a
// pipelined request/response instruction memory. Requests are issued on a
// credit basis so the queue can never overflow: queued entries plus
// in-flight fetches never exceed DEPTH. A taken branch empties the queue,
// marks every in-flight fetch for discard and pulses flush one cycle later.

module if_prefetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branchTaken,
   input  logic [ADDR_W-1:0] branchAddress,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instruction,
   output logic              flush
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Prefetch queue storage and the in-order address FIFO for in-flight fetches
   logic [ADDR_W-1:0] r_qAddr  [DEPTH];
   logic [DATA_W-1:0] r_qInstr [DEPTH];
   logic [ADDR_W-1:0] r_afAddr [DEPTH];

   logic [ADDR_W-1:0] r_fetchPc;
   logic [PW-1:0]     r_rdPtr;
   logic [PW-1:0]     r_wrPtr;
   logic [PW-1:0]     r_afRd;
   logic [PW-1:0]     r_afWr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     r_drop;
   logic              r_flush;

   logic [CW:0]       w_credit;
   logic              w_accept;
   logic              w_enq;
   logic              w_deq;
   logic              w_dropResp;
   logic [CW-1:0]     w_outNext;
   logic [CW-1:0]     w_countNext;

   // Issue side: a request may go out only while credits remain and no redirect is happening
   always_comb begin
      w_credit    = {1'b0, r_count} + {1'b0, r_outstanding};
      imem_req    = rst && !branchTaken && (w_credit < (CW+1)'(DEPTH));
      imem_addr   = r_fetchPc;
      w_accept    = imem_req && imem_ready;
      w_dropResp  = imem_rvalid && (r_drop != '0);
      w_enq       = imem_rvalid && (r_drop == '0) && !branchTaken;
      w_deq       = valid && !freeze && !branchTaken;
      w_outNext   = r_outstanding + CW'(w_accept) - CW'(imem_rvalid);
      w_countNext = r_count + CW'(w_enq) - CW'(w_deq);
   end

   // Head-of-queue outputs, forced to zero while the queue is empty
   always_comb begin
      valid       = (r_count != '0);
      pc          = '0;
      instruction = '0;
      if (valid) begin
         pc          = r_qAddr[r_rdPtr] + ADDR_W'(PC_STEP);
         instruction = r_qInstr[r_rdPtr];
      end
      flush = r_flush;
   end

   // Control state: fetch PC, queue pointers, credit and discard counters, flush pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetchPc     <= RESET_PC;
         r_rdPtr       <= '0;
         r_wrPtr       <= '0;
         r_afRd        <= '0;
         r_afWr        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_flush       <= 1'b0;
      end else begin
         r_flush       <= branchTaken;
         r_outstanding <= w_outNext;
         if (w_accept) begin
            r_afWr <= r_afWr + 1'b1;
         end
         if (imem_rvalid) begin
            r_afRd <= r_afRd + 1'b1;
         end
         if (branchTaken) begin
            r_fetchPc <= branchAddress;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_drop    <= w_outNext;
         end else begin
            if (w_accept) begin
               r_fetchPc <= r_fetchPc + ADDR_W'(PC_STEP);
            end
            if (w_enq) begin
               r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_deq) begin
               r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
            if (w_dropResp) begin
               r_drop <= r_drop - 1'b1;
            end
         end
      end
   end

   // Storage writes; contents need no reset because the empty queue hides them
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_afAddr[r_afWr] <= r_fetchPc;
      end
      if (w_enq) begin
         r_qAddr[r_wrPtr]  <= r_afAddr[r_afRd];
         r_qInstr[r_wrPtr] <= imem_rdata;
      end
   end

endmodule
